dmem_arb: RTL
=============

DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have parameters: AW, default 8, address width; DW, default 8, data width; MAX_BURST, default 64, maximum consecutive granted cycles while the other client waits.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 init  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 req0/req1  input  1 each  client access request, level-held.
REQ-005 wen0/wen1  input  1 each  client write enable, meaningful only while the matching gnt is high.
REQ-006 raddr0/raddr1, waddr0/waddr1  input  AW each  client read/write address.
REQ-007 wdata0/wdata1  input  DW each  client write data.
REQ-008 gnt0/gnt1  output  1 each  registered grant; at most one high.
REQ-009 rdata  output  DW  m_rdata forwarded combinationally to both clients.
REQ-010 m_wen  output  1; m_raddr, m_waddr  output  AW; m_wdata  output  DW  memory-side port.
REQ-011 m_rdata  input  DW  memory read data.
REQ-012 preempt  output  1  one-cycle pulse when a grant is revoked by the burst limit.

Function
REQ-013 FSM SHALL have states IDLE, OWN0 and OWN1; gnt0 = (state==OWN0) and gnt1 = (state==OWN1).
REQ-014 IDLE SHALL go to OWN0 if only req0 is high, to OWN1 if only req1 is high, and stay in IDLE if neither is high.
REQ-015 IDLE with req0 and req1 both high SHALL grant the client that is not recorded in the last-served register last.
REQ-016 Entering OWNx SHALL set last to x and clear the burst counter bcnt to 0.
REQ-017 In OWNx, bcnt SHALL increment each cycle and saturate at MAX_BURST-1.
REQ-018 OWNx SHALL go to IDLE when reqx is low.
REQ-019 OWNx SHALL also go to IDLE when bcnt == MAX_BURST-1 and the other req is high; preempt SHALL be high in that same cycle.
REQ-020 OWNx with bcnt at saturation and the other req low SHALL stay in OWNx for an unbounded time.
REQ-021 Minimum hand-over SHALL be one IDLE cycle: grant latency from req rising in IDLE is 1 cycle.
REQ-022 Memory-side mux SHALL be purely combinational from owner inputs:
- m_wen = gntx & wenx;
- m_raddr, m_waddr and m_wdata are the owner's values;
- all memory-side outputs are 0 in IDLE.
REQ-023 Writes SHALL occur only while granted; wen from a non-owner is ignored.
REQ-024 A client whose req drops and rises in the same cycle SHALL see no effect; requests are level-sampled only.
REQ-025 A preempted client SHALL keep req high and be re-granted, with no request lost, after the other client's tenure ends.

Reset
REQ-026 init high SHALL, on the next posedge, force state=IDLE, bcnt=0 and last=1, so client 0 wins the first tie.
REQ-027 During and after reset: gnt0=gnt1=0, preempt=0, m_wen=0, m_raddr=m_waddr=0, m_wdata=0.
REQ-028 init asserted mid-tenure SHALL drop the grant the following cycle, with no write in that cycle once init is sampled.
REQ-029 Reset SHALL take priority over all transitions.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, OWN0, OWN1) and the client-index typedef; encoder and decoder reuse it.
REQ-031 No sub-module is required; the burst counter is inline.
REQ-032 dmem_arb SHALL sit between the encoder/decoder engines and the single dmem instance.

Verification
REQ-033 Scenario 1: reset, then req0=1 alone -> gnt0=1 on the next cycle; write waddr0=5, wdata0=8'hA5 -> m_wen=1, m_waddr=5, m_wdata=A5.
REQ-034 Scenario 2: req0 and req1 rise together after reset -> gnt0 first; after req0 drops, one IDLE cycle, then gnt1.
REQ-035 Scenario 3: MAX_BURST=4, req0 and req1 both held high -> gnt0 for 4 cycles, preempt pulse, IDLE, gnt1 for 4 cycles, and so on alternately.
REQ-036 Scenario 4: req1 alone held for 100 cycles with MAX_BURST=4 -> gnt1 continuous, preempt never asserted.
REQ-037 Scenario 5: wen1=1 while gnt0 is high -> m_wen follows wen0 only; checked for 10 random cycles.
REQ-038 Scenario 6: init pulsed during OWN1 -> next cycle gnt1=0 and m_wen=0; the following tie (req0 and req1 both high) goes to client 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter and the encoder/decoder engines
// that sit on either side of it.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Client index: 0 or 1.
  typedef logic client_t;

  function automatic arb_state_e own_state(input client_t c);
    return c ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/dmem_arb.sv
// Two-client arbiter in front of the single dmem instance: round-robin on
// ties, burst limit with preemption, combinational memory-side mux.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 64
) (
  input  logic          clk,
  input  logic          init,
  input  logic          req0,
  input  logic          req1,
  input  logic          wen0,
  input  logic          wen1,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] waddr0,
  input  logic [AW-1:0] waddr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata,
  output logic          m_wen,
  output logic [AW-1:0] m_raddr,
  output logic [AW-1:0] m_waddr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          preempt
);

  localparam int            BW   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST - 1);

  arb_state_e    state_q, state_d;
  client_t       last_q, last_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          preempt_c;
  logic          own_req, oth_req;
  client_t       winner;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    last_d    = last_q;
    bcnt_d    = bcnt_q;
    preempt_c = 1'b0;
    own_req   = (state_q == OWN1) ? req1 : req0;
    oth_req   = (state_q == OWN1) ? req0 : req1;
    winner    = req0 ? 1'b0 : 1'b1;
    if (req0 && req1) winner = ~last_q;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = own_state(winner);
          last_d  = winner;
          bcnt_d  = '0;
        end
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          state_d = IDLE;
        end else if (bcnt_q == BMAX && oth_req) begin
          state_d   = IDLE;
          preempt_c = 1'b1;
        end else if (bcnt_q != BMAX) begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last resets to client 1 so that client 0 wins the first tie.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (init) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign gnt0    = (state_q == OWN0);
  assign gnt1    = (state_q == OWN1);
  assign preempt = preempt_c & ~init;
  assign rdata   = m_rdata;

  always_comb begin
    m_wen   = 1'b0;
    m_raddr = '0;
    m_waddr = '0;
    m_wdata = '0;
    unique case (state_q)
      OWN0: begin
        m_wen   = wen0;
        m_raddr = raddr0;
        m_waddr = waddr0;
        m_wdata = wdata0;
      end
      OWN1: begin
        m_wen   = wen1;
        m_raddr = raddr1;
        m_waddr = waddr1;
        m_wdata = wdata1;
      end
      default: ;
    endcase
  end

endmodule
